// File: rtl/spdif_pkg.sv
// Shared S/PDIF framing constants: preambles, frame geometry, slot map
// and channel-status bit positions.
package spdif_pkg;

    localparam int DATA_W           = 16;
    localparam int CELLS_PER_FRAME  = 128;
    localparam int FRAMES_PER_BLOCK = 192;

    localparam logic [6:0] LAST_CELL  = 7'(CELLS_PER_FRAME - 1);
    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);

    // Preamble half-cell patterns, first-transmitted cell in the MSB,
    // written for a line that was low before the preamble.
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    localparam logic [4:0] SLOT_AUX        = 5'd4;
    localparam logic [4:0] SLOT_AUDIO      = 5'd12;
    localparam logic [4:0] SLOT_AUDIO_LAST = 5'd27;
    localparam logic [4:0] SLOT_V          = 5'd28;
    localparam logic [4:0] SLOT_U          = 5'd29;
    localparam logic [4:0] SLOT_C          = 5'd30;
    localparam logic [4:0] SLOT_P          = 5'd31;

    localparam logic [7:0] CS_COPY_BIT   = 8'd2;
    localparam logic [7:0] CS_RATE_FIRST = 8'd24;

    function automatic logic [7:0] preamble_sel(input logic right, input logic block_start);
        if (right) return PRE_W;
        return block_start ? PRE_B : PRE_M;
    endfunction

endpackage

// File: rtl/spdif_channel_status.sv
// Consumer channel-status block: returns the C bit carried by a given
// frame of the 192-frame block.
module spdif_channel_status
    import spdif_pkg::*;
#(
    parameter bit         CopyPermit     = 1'b1,
    parameter logic [3:0] SampleRateCode = 4'b0100
) (
    input  logic [7:0] frame_idx,
    output logic       c_bit
);

    logic [7:0] rate_off;

    assign rate_off = frame_idx - CS_RATE_FIRST;

    // Sample-rate code goes out MSB first, so offset k selects bit 3-k.
    always_comb begin
        c_bit = 1'b0;
        if (frame_idx == CS_COPY_BIT) begin
            c_bit = CopyPermit;
        end else if (rate_off < 8'd4) begin
            c_bit = SampleRateCode[~rate_off[1:0]];
        end
    end

endmodule

// File: rtl/spdif_transmitter.sv
// Stereo 16-bit S/PDIF transmitter: single-entry sample buffer, frame and
// cell counters, and a biphase-mark line encoder advanced by Cell_Ena.
module spdif_transmitter
    import spdif_pkg::*;
#(
    parameter bit         CopyPermit     = 1'b1,
    parameter logic [3:0] SampleRateCode = 4'b0100
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Cell_Ena,
    input  logic                     Enable,
    input  logic                     Sample_Valid,
    input  logic signed [DATA_W-1:0] Left,
    input  logic signed [DATA_W-1:0] Right,
    output logic                     S_PDIF_Out,
    output logic                     nS_PDIF,
    output logic                     Frame_Start,
    output logic                     Underrun,
    output logic                     Overrun
);

    logic [6:0]               cell_p0;
    logic [7:0]               frame_p0;
    logic                     fresh_p0;
    logic                     pend_vld_p0;
    logic signed [DATA_W-1:0] pend_l_p0;
    logic signed [DATA_W-1:0] pend_r_p0;
    logic signed [DATA_W-1:0] tx_l_p0;
    logic signed [DATA_W-1:0] tx_r_p0;
    logic                     tx_v_p0;
    logic                     pre_pol_p0;

    logic lvl_p1;
    logic nlvl_p1;
    logic fs_p1;
    logic und_p1;
    logic ovr_p1;

    logic                     subframe;
    logic                     half;
    logic [4:0]               slot;
    logic [3:0]               aidx;
    logic [2:0]               pre_idx;
    logic [7:0]               pre_pat;
    logic                     pre_ref;
    logic signed [DATA_W-1:0] sample;
    logic                     c_bit;
    logic                     parity;
    logic                     slot_bit;
    logic                     next_lvl;
    logic                     xfer;

    assign subframe = cell_p0[6];
    assign slot     = cell_p0[5:1];
    assign half     = cell_p0[0];
    assign aidx     = slot[3:0] - SLOT_AUDIO[3:0];
    assign pre_idx  = {slot[1:0], half};
    assign sample   = subframe ? tx_r_p0 : tx_l_p0;
    assign parity   = ^{sample, tx_v_p0, c_bit};
    assign pre_pat  = preamble_sel(subframe, frame_p0 == 8'd0);

    // A fresh start (after reset or enable) loads on its first cell so
    // frame 0 still gets a sample or an underrun decision.
    assign xfer = Cell_Ena && (cell_p0 == LAST_CELL || fresh_p0);

    spdif_channel_status #(
        .CopyPermit    (CopyPermit),
        .SampleRateCode(SampleRateCode)
    ) u_channel_status (
        .frame_idx(frame_p0),
        .c_bit    (c_bit)
    );

    always_comb begin
        slot_bit = 1'b0;
        if (slot >= SLOT_AUDIO && slot <= SLOT_AUDIO_LAST) begin
            slot_bit = sample[aidx];
        end else begin
            case (slot)
                SLOT_V:  slot_bit = tx_v_p0;
                SLOT_U:  slot_bit = 1'b0;
                SLOT_C:  slot_bit = c_bit;
                SLOT_P:  slot_bit = parity;
                default: slot_bit = 1'b0;
            endcase
        end
    end

    // Preamble polarity follows the line level just before the preamble.
    always_comb begin
        pre_ref  = (pre_idx == 3'd0) ? lvl_p1 : pre_pol_p0;
        next_lvl = lvl_p1;
        if (slot < SLOT_AUX) begin
            next_lvl = pre_pat[~pre_idx] ^ pre_ref;
        end else if (!half) begin
            next_lvl = ~lvl_p1;
        end else begin
            next_lvl = lvl_p1 ^ slot_bit;
        end
    end

    // p0 -> p1: counters and buffers advance, line level registered
    always_ff @(posedge Clk) begin
        fs_p1  <= 1'b0;
        und_p1 <= 1'b0;
        ovr_p1 <= 1'b0;
        if (Reset) begin
            cell_p0     <= '0;
            frame_p0    <= '0;
            fresh_p0    <= 1'b1;
            pend_vld_p0 <= 1'b0;
            pend_l_p0   <= '0;
            pend_r_p0   <= '0;
            tx_l_p0     <= '0;
            tx_r_p0     <= '0;
            tx_v_p0     <= 1'b0;
            pre_pol_p0  <= 1'b0;
            lvl_p1      <= 1'b0;
            nlvl_p1     <= 1'b1;
        end else if (!Enable) begin
            cell_p0     <= '0;
            frame_p0    <= '0;
            fresh_p0    <= 1'b1;
            pend_vld_p0 <= 1'b0;
            lvl_p1      <= 1'b0;
            nlvl_p1     <= 1'b1;
        end else begin
            if (Cell_Ena) begin
                lvl_p1   <= next_lvl;
                nlvl_p1  <= ~next_lvl;
                fs_p1    <= (cell_p0 == 7'd0);
                fresh_p0 <= 1'b0;
                cell_p0  <= cell_p0 + 7'd1;
                if (cell_p0[5:0] == 6'd0) begin
                    pre_pol_p0 <= lvl_p1;
                end
                if (cell_p0 == LAST_CELL) begin
                    frame_p0 <= (frame_p0 == LAST_FRAME) ? 8'd0 : frame_p0 + 8'd1;
                end
            end
            if (xfer) begin
                pend_vld_p0 <= 1'b0;
                if (Sample_Valid) begin
                    tx_l_p0 <= Left;
                    tx_r_p0 <= Right;
                    tx_v_p0 <= 1'b0;
                end else if (pend_vld_p0) begin
                    tx_l_p0 <= pend_l_p0;
                    tx_r_p0 <= pend_r_p0;
                    tx_v_p0 <= 1'b0;
                end else begin
                    tx_l_p0 <= '0;
                    tx_r_p0 <= '0;
                    tx_v_p0 <= 1'b1;
                    und_p1  <= 1'b1;
                end
            end else if (Sample_Valid) begin
                pend_l_p0   <= Left;
                pend_r_p0   <= Right;
                pend_vld_p0 <= 1'b1;
                ovr_p1      <= pend_vld_p0;
            end
        end
    end

    assign S_PDIF_Out  = lvl_p1;
    assign nS_PDIF     = nlvl_p1;
    assign Frame_Start = fs_p1;
    assign Underrun    = und_p1;
    assign Overrun     = ovr_p1;

endmodule

// File: tb/tb_spdif_transmitter.sv
// Self-checking bench for spdif_transmitter: cell-level reference model plus
// frame decoding of the DUT line against table and hand-written expectations.
module tb_spdif_transmitter;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Cell_Ena;
    logic               Enable;
    logic               Sample_Valid;
    logic signed [15:0] Left;
    logic signed [15:0] Right;
    logic               S_PDIF_Out;
    logic               nS_PDIF;
    logic               Frame_Start;
    logic               Underrun;
    logic               Overrun;

    int checks = 0;
    int errors = 0;

    spdif_transmitter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Cell_Ena    (Cell_Ena),
        .Enable      (Enable),
        .Sample_Valid(Sample_Valid),
        .Left        (Left),
        .Right       (Right),
        .S_PDIF_Out  (S_PDIF_Out),
        .nS_PDIF     (nS_PDIF),
        .Frame_Start (Frame_Start),
        .Underrun    (Underrun),
        .Overrun     (Overrun)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    int          m_cell, m_frame;
    bit          m_fresh, m_pend;
    logic [15:0] m_pl, m_pr, m_tl, m_tr;
    logic        m_tv, m_level;
    logic        exp_cells[128];

    // Captured DUT line and decoded frame fields
    logic        got[128];
    logic        got_prior;
    int          und_seen, ovr_seen;
    logic [7:0]  dec_pre[2];
    logic [15:0] dec_smp[2];
    logic        dec_v[2], dec_c[2], dec_par[2];

    typedef struct {
        bit          load;
        logic [15:0] l, r;
        logic [15:0] exp_l, exp_r;
        logic        exp_v;
        logic [7:0]  exp_pre;
        int          cum_und;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic cs_exp(input int n);
        logic [3:0] rate;
        rate = 4'b0100;
        if (n == 2) return 1'b1;
        if (n >= 24 && n <= 27) return rate[27 - n];
        return 1'b0;
    endfunction

    task automatic build_frame(input int fr, input logic [15:0] l, input logic [15:0] r,
                               input logic v, input logic prior);
        logic       bits[32];
        logic [7:0] pre;
        logic [15:0] smp;
        logic       lvl, p;
        lvl = prior;
        for (int sf = 0; sf < 2; sf++) begin
            smp = (sf == 1) ? r : l;
            for (int s = 0; s < 32; s++) bits[s] = 1'b0;
            for (int k = 0; k < 16; k++) bits[12 + k] = smp[k];
            bits[28] = v;
            bits[30] = cs_exp(fr);
            p = 1'b0;
            for (int s = 4; s < 31; s++) p ^= bits[s];
            bits[31] = p;
            pre = (sf == 1) ? 8'b11100100 : ((fr == 0) ? 8'b11101000 : 8'b11100010);
            for (int k = 0; k < 8; k++) exp_cells[sf * 64 + k] = pre[7 - k] ^ lvl;
            lvl = exp_cells[sf * 64 + 7];
            for (int s = 4; s < 32; s++) begin
                lvl = ~lvl;
                exp_cells[sf * 64 + 2 * s] = lvl;
                if (bits[s]) lvl = ~lvl;
                exp_cells[sf * 64 + 2 * s + 1] = lvl;
            end
        end
    endtask

    task automatic tick(input logic ce, input logic sv, input logic [15:0] l, input logic [15:0] r);
        logic e_fs, e_und, e_ovr, prev;
        int   emit;
        e_fs = 1'b0; e_und = 1'b0; e_ovr = 1'b0; emit = -1;
        Cell_Ena = ce; Sample_Valid = sv; Left = l; Right = r;
        prev = S_PDIF_Out;
        if (Reset) begin
            m_cell = 0; m_frame = 0; m_fresh = 1'b1; m_pend = 1'b0; m_level = 1'b0;
            m_tl = '0; m_tr = '0; m_tv = 1'b0;
        end else if (!Enable) begin
            m_cell = 0; m_frame = 0; m_fresh = 1'b1; m_pend = 1'b0; m_level = 1'b0;
        end else begin
            if (ce && (m_cell == 127 || m_fresh)) begin
                if (sv) begin
                    m_tl = l; m_tr = r; m_tv = 1'b0;
                end else if (m_pend) begin
                    m_tl = m_pl; m_tr = m_pr; m_tv = 1'b0;
                end else begin
                    m_tl = '0; m_tr = '0; m_tv = 1'b1; e_und = 1'b1;
                end
                m_pend = 1'b0;
            end else if (sv) begin
                e_ovr = m_pend;
                m_pend = 1'b1; m_pl = l; m_pr = r;
            end
            if (ce) begin
                if (m_cell == 0) build_frame(m_frame, m_tl, m_tr, m_tv, m_level);
                e_fs = (m_cell == 0);
                emit = m_cell;
                m_level = exp_cells[m_cell];
                m_fresh = 1'b0;
                m_cell = (m_cell + 1) % 128;
                if (m_cell == 0) m_frame = (m_frame + 1) % 192;
            end
        end
        @(posedge Clk);
        #1;
        check($sformatf("line f%0d c%0d", m_frame, emit),
              32'({S_PDIF_Out, nS_PDIF, Frame_Start, Underrun, Overrun}),
              32'({m_level, ~m_level, e_fs, e_und, e_ovr}));
        if (Underrun) und_seen++;
        if (Overrun) ovr_seen++;
        if (emit >= 0) begin
            got[emit] = S_PDIF_Out;
            if (emit == 0) got_prior = prev;
        end
        Cell_Ena = 1'b0;
        Sample_Valid = 1'b0;
    endtask

    task automatic cells(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) tick(1'b0, 1'b0, 16'h0, 16'h0);
            tick(1'b1, 1'b0, 16'h0, 16'h0);
        end
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        tick(1'b0, 1'b1, l, r);
    endtask

    task automatic decode();
        logic prior, b, par;
        int   base;
        for (int sf = 0; sf < 2; sf++) begin
            base  = sf * 64;
            prior = (sf == 1) ? got[63] : got_prior;
            for (int k = 0; k < 8; k++) dec_pre[sf][7 - k] = got[base + k] ^ prior;
            par = 1'b0;
            for (int s = 4; s < 32; s++) begin
                b = got[base + 2 * s] ^ got[base + 2 * s + 1];
                par ^= b;
                if (s >= 12 && s <= 27) dec_smp[sf][s - 12] = b;
                if (s == 28) dec_v[sf] = b;
                if (s == 30) dec_c[sf] = b;
            end
            dec_par[sf] = par;
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er,
                               input logic ev, input logic [7:0] epre);
        decode();
        check({tag, " pre_l"}, 32'(dec_pre[0]), 32'(epre));
        check({tag, " pre_r"}, 32'(dec_pre[1]), 32'(8'b11100100));
        check({tag, " left"}, 32'(dec_smp[0]), 32'(el));
        check({tag, " right"}, 32'(dec_smp[1]), 32'(er));
        check({tag, " v"}, 32'({dec_v[0], dec_v[1]}), 32'({ev, ev}));
        check({tag, " parity"}, 32'({dec_par[0], dec_par[1]}), 32'(2'b00));
    endtask

    initial begin
        int u0, o0, bcount;
        logic e;
        tbl[0] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 1'b0, 8'b11101000, 1};
        tbl[1] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 8'b11100010, 2};
        tbl[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 8'b11100010, 3};
        tbl[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 8'b11100010, 3};
        tbl[4] = '{1'b1, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 1'b0, 8'b11100010, 4};

        Reset = 1'b1; Enable = 1'b0; Cell_Ena = 1'b0; Sample_Valid = 1'b0;
        Left = '0; Right = '0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 16'h5A5A, 16'hA5A5);
        check("reset_out", 32'({S_PDIF_Out, nS_PDIF, Frame_Start, Underrun, Overrun}), 32'(5'b01000));
        Reset = 1'b0; Enable = 1'b1;
        tick(1'b0, 1'b0, 16'h0, 16'h0);
        und_seen = 0; ovr_seen = 0;

        // Load, underrun run and recovery
        if (tbl[0].load) strobe(tbl[0].l, tbl[0].r);
        for (int i = 0; i < 5; i++) begin
            cells(64);
            if (i < 4 && tbl[i + 1].load) strobe(tbl[i + 1].l, tbl[i + 1].r);
            cells(64);
            check_frame($sformatf("tbl%0d", i), tbl[i].exp_l, tbl[i].exp_r, tbl[i].exp_v, tbl[i].exp_pre);
            check($sformatf("tbl%0d underruns", i), 32'(und_seen), 32'(tbl[i].cum_und));
        end

        // Two strobes in one frame: last pair wins, one overrun
        o0 = ovr_seen;
        cells(32); strobe(16'h1111, 16'h2222);
        cells(10); strobe(16'h3333, 16'h4444);
        cells(86);
        check("overrun_count", 32'(ovr_seen - o0), 32'd1);
        cells(128);
        check_frame("overrun", 16'h3333, 16'h4444, 1'b0, 8'b11100010);

        // Strobe coincident with the cell-127 load
        cells(127);
        u0 = und_seen; o0 = ovr_seen;
        tick(1'b1, 1'b1, 16'h5555, 16'h6666);
        check("coincident_und", 32'(und_seen - u0), 32'd0);
        check("coincident_ovr", 32'(ovr_seen - o0), 32'd0);
        cells(128);
        check_frame("coincident", 16'h5555, 16'h6666, 1'b0, 8'b11100010);

        // Reset at cell 70
        cells(70);
        Reset = 1'b1;
        tick(1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
        check("midreset_out", 32'({S_PDIF_Out, nS_PDIF}), 32'(2'b01));
        Reset = 1'b0;
        tick(1'b0, 1'b0, 16'h0, 16'h0);
        strobe(16'h0F0F, 16'hF0F0);
        cells(128);
        check_frame("after_reset", 16'h0F0F, 16'hF0F0, 1'b0, 8'b11101000);

        // Enable drop mid-frame, then a full channel-status block
        cells(30);
        Enable = 1'b0;
        tick(1'b1, 1'b0, 16'h0, 16'h0);
        check("disable_out", 32'({S_PDIF_Out, nS_PDIF}), 32'(2'b01));
        tick(1'b0, 1'b1, 16'h7777, 16'h7777);
        Enable = 1'b1;
        strobe(16'hA5A5, 16'h5A5A);
        bcount = 0;
        for (int f = 0; f < 192; f++) begin
            cells(64);
            strobe(16'hA5A5, 16'h5A5A);
            cells(64);
            decode();
            e = (f == 2 || f == 25);
            check($sformatf("cbit f%0d", f), 32'({dec_c[0], dec_c[1]}), 32'({e, e}));
            if (dec_pre[0] == 8'b11101000) bcount++;
            if (f == 0) check("block_pre0", 32'(dec_pre[0]), 32'(8'b11101000));
            if (f == 100) check("block_payload", 32'({dec_smp[0], dec_smp[1]}), 32'h A5A55A5A);
        end
        check("block_bcount", 32'(bcount), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
